// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and a synchronous-read instruction
// memory, and presents a registered {pc, inst, valid} triple to IF/ID.
module if_fetch_stage #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    IMEM_DEPTH = 256,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          redirect_en,
    input  logic [PC_WIDTH-1:0]           redirect_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [INST_WIDTH-1:0]         imem_wdata,
    output logic [PC_WIDTH-1:0]           pc_out,
    output logic [INST_WIDTH-1:0]         inst_out,
    output logic                          valid_out,
    output logic [31:0]                   fetch_count
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic [INST_WIDTH-1:0] imem [IMEM_DEPTH];

    logic [PC_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [PC_WIDTH-1:0]   pc_out_reg, pc_out_next;
    logic [INST_WIDTH-1:0] inst_reg;
    logic                  valid_reg, valid_next;
    logic [31:0]           count_reg, count_next;
    logic [IDX_W-1:0]      fetch_idx;

    // Upper PC bits are ignored, so addresses alias onto the memory.
    assign fetch_idx = fetch_pc_reg[IDX_W-1:0];

    // Program-load port; honoured even while rst is asserted.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Registered read doubles as the inst_out register; nonblocking semantics
    // give old data when the same word is written in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || redirect_en) begin
            inst_reg <= '0;
        end else if (!stall) begin
            inst_reg <= imem[fetch_idx];
        end
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        pc_out_next   = pc_out_reg;
        valid_next    = valid_reg;
        count_next    = count_reg;
        if (redirect_en) begin
            // Wrong-path fetch is squashed; pc_out is informational only.
            fetch_pc_next = redirect_target;
            pc_out_next   = fetch_pc_reg;
            valid_next    = 1'b0;
        end else if (!stall) begin
            fetch_pc_next = fetch_pc_reg + PC_WIDTH'(1);
            pc_out_next   = fetch_pc_reg;
            valid_next    = 1'b1;
            count_next    = count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            pc_out_reg   <= '0;
            valid_reg    <= 1'b0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            pc_out_reg   <= pc_out_next;
            valid_reg    <= valid_next;
            count_reg    <= count_next;
        end
    end

    assign pc_out      = pc_out_reg;
    assign inst_out    = inst_reg;
    assign valid_out   = valid_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a vector table on the main instance plus a
// hand-written sequence on a second instance whose reset PC sits at the top of memory.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst, stall, redirect_en, imem_we;
    logic [31:0] redirect_target, imem_wdata;
    logic [7:0]  imem_waddr;
    logic [31:0] pc_out, inst_out, fetch_count;
    logic        valid_out;

    logic        w_rst, w_stall, w_redirect_en, w_imem_we;
    logic [31:0] w_redirect_target, w_imem_wdata;
    logic [7:0]  w_imem_waddr;
    logic [31:0] w_pc_out, w_inst_out, w_fetch_count;
    logic        w_valid_out;

    int applied = 0;
    int miscompares = 0;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
        .redirect_target(redirect_target), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc_out(pc_out), .inst_out(inst_out), .valid_out(valid_out),
        .fetch_count(fetch_count)
    );

    if_fetch_stage #(.RESET_PC(32'hFF)) dut_wrap (
        .clk(clk), .rst(w_rst), .stall(w_stall), .redirect_en(w_redirect_en),
        .redirect_target(w_redirect_target), .imem_we(w_imem_we),
        .imem_waddr(w_imem_waddr), .imem_wdata(w_imem_wdata),
        .pc_out(w_pc_out), .inst_out(w_inst_out), .valid_out(w_valid_out),
        .fetch_count(w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] tgt;
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc, inst;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [31:0] inst, input logic v,
                       input logic [31:0] cnt);
        vec_t e;
        e.rst = r; e.stall = s; e.redir = rd; e.tgt = tgt;
        e.we = we; e.waddr = wa; e.wdata = wd;
        e.pc = pc; e.inst = inst; e.valid = v; e.cnt = cnt;
        vecs.push_back(e);
    endtask

    task automatic check(input string name,
                         input logic [31:0] apc, input logic [31:0] ainst, input logic av,
                         input logic [31:0] acnt,
                         input logic [31:0] epc, input logic [31:0] einst, input logic ev,
                         input logic [31:0] ecnt);
        applied++;
        if (apc !== epc || ainst !== einst || av !== ev || acnt !== ecnt) begin
            miscompares++;
            $display("FAIL %s: got pc=%h inst=%h valid=%b cnt=%0d, want pc=%h inst=%h valid=%b cnt=%0d",
                     name, apc, ainst, av, acnt, epc, einst, ev, ecnt);
        end else begin
            $display("ok   %s: pc=%h inst=%h valid=%b cnt=%0d", name, apc, ainst, av, acnt);
        end
    endtask

    logic [7:0]  load_addr [19];
    logic [31:0] load_data [19];

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_target = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        w_rst = 1'b1; w_stall = 1'b0; w_redirect_en = 1'b0; w_redirect_target = '0;
        w_imem_we = 1'b0; w_imem_waddr = '0; w_imem_wdata = '0;

        // Program: imem[i]=0xA0+i except imem[5]=0x11; targets at 0x40/0x41/0xFF.
        for (int i = 0; i < 16; i++) begin
            load_addr[i] = 8'(i);
            load_data[i] = (i == 5) ? 32'h11 : 32'hA0 + 32'(i);
        end
        load_addr[16] = 8'h40; load_data[16] = 32'hBB;
        load_addr[17] = 8'h41; load_data[17] = 32'hBC;
        load_addr[18] = 8'hFF; load_data[18] = 32'hCF;

        // Vector table: inputs for one posedge, then expected outputs after it.
        //   rst  stl  rd   tgt            we   wa     wd          pc             inst      v     cnt
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h0,        32'h0,    1'b0, 32'd0);  // reset held
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h0,        32'hA0,   1'b1, 32'd1);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h1,        32'hA1,   1'b1, 32'd2);
        add(1'b0,1'b1,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h1,        32'hA1,   1'b1, 32'd2);  // stall x3
        add(1'b0,1'b1,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h1,        32'hA1,   1'b1, 32'd2);
        add(1'b0,1'b1,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h1,        32'hA1,   1'b1, 32'd2);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h2,        32'hA2,   1'b1, 32'd3);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h3,        32'hA3,   1'b1, 32'd4);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h4,        32'hA4,   1'b1, 32'd5);
        add(1'b0,1'b0,1'b0,32'h0,        1'b1,8'h5,  32'h22,     32'h5,        32'h11,   1'b1, 32'd6);  // read-before-write
        add(1'b0,1'b1,1'b1,32'h40,       1'b0,8'h0,  32'h0,      32'h6,        32'h0,    1'b0, 32'd6);  // redirect beats stall
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h40,       32'hBB,   1'b1, 32'd7);
        add(1'b0,1'b0,1'b1,32'h10,       1'b0,8'h0,  32'h0,      32'h41,       32'h0,    1'b0, 32'd7);  // back-to-back redirects
        add(1'b0,1'b0,1'b1,32'h5,        1'b0,8'h0,  32'h0,      32'h10,       32'h0,    1'b0, 32'd7);
        add(1'b0,1'b1,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h10,       32'h0,    1'b0, 32'd7);  // stall holds squash
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h5,        32'h22,   1'b1, 32'd8);  // new data visible
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h6,        32'hA6,   1'b1, 32'd9);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h7,        32'hA7,   1'b1, 32'd10);
        add(1'b1,1'b1,1'b1,32'h40,       1'b0,8'h0,  32'h0,      32'h0,        32'h0,    1'b0, 32'd0);  // mid-run reset wins
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h0,        32'hA0,   1'b1, 32'd1);
        add(1'b0,1'b0,1'b1,32'h141,      1'b0,8'h0,  32'h0,      32'h1,        32'h0,    1'b0, 32'd1);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h141,      32'hBC,   1'b1, 32'd2);  // aliased index 0x41
        add(1'b0,1'b0,1'b1,32'hFFFFFFFF, 1'b0,8'h0,  32'h0,      32'h142,      32'h0,    1'b0, 32'd2);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'hFFFFFFFF, 32'hCF,   1'b1, 32'd3);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,8'h0,  32'h0,      32'h0,        32'hA0,   1'b1, 32'd4);  // PC wraps to 0

        @(posedge clk); #1;
        // Load both memories while their resets are held.
        for (int i = 0; i < 19; i++) begin
            imem_we = 1'b1; imem_waddr = load_addr[i]; imem_wdata = load_data[i];
            if (i == 0) begin
                w_imem_we = 1'b1; w_imem_waddr = 8'hFF; w_imem_wdata = 32'hC1;
            end else if (i == 1) begin
                w_imem_we = 1'b1; w_imem_waddr = 8'h00; w_imem_wdata = 32'hC2;
            end else begin
                w_imem_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        imem_we = 1'b0;
        check("wrap_reset", w_pc_out, w_inst_out, w_valid_out, w_fetch_count,
              32'h0, 32'h0, 1'b0, 32'd0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; stall = vecs[i].stall; redirect_en = vecs[i].redir;
            redirect_target = vecs[i].tgt; imem_we = vecs[i].we;
            imem_waddr = vecs[i].waddr; imem_wdata = vecs[i].wdata;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), pc_out, inst_out, valid_out, fetch_count,
                  vecs[i].pc, vecs[i].inst, vecs[i].valid, vecs[i].cnt);
        end
        rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; imem_we = 1'b0;

        // Reset PC at the top of memory: the next PC leaves the index range and aliases to 0.
        w_rst = 1'b0;
        @(posedge clk); #1;
        check("wrap_first", w_pc_out, w_inst_out, w_valid_out, w_fetch_count,
              32'hFF, 32'hC1, 1'b1, 32'd1);
        @(posedge clk); #1;
        check("wrap_alias", w_pc_out, w_inst_out, w_valid_out, w_fetch_count,
              32'h100, 32'hC2, 1'b1, 32'd2);
        w_stall = 1'b1;
        @(posedge clk); #1;
        check("wrap_stall", w_pc_out, w_inst_out, w_valid_out, w_fetch_count,
              32'h100, 32'hC2, 1'b1, 32'd2);
        w_stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
